// File: rtl/ni_fifo_arbiter.sv
// Round-robin, packet-locked arbiter sharing one NoC injection FIFO write
// port among N head/body/tail flit sources. A granted source keeps the port
// until its tail flit is forwarded or the stall watchdog releases it.
module ni_fifo_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    Req_i,
    input  logic [N-1:0]    FifoWr_i,
    input  logic [32*N-1:0] FifoWrData_i,
    output logic [N-1:0]    FullOut_o,
    output logic [N-1:0]    Gnt_o,
    input  logic            FifoFull_i,
    output logic            FifoWr_o,
    output logic [31:0]     FifoWrData_o,
    output logic            Timeout_o,
    output logic            Err_o,
    output logic [15:0]     PktCnt_o
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg;
    logic [N-1:0]    gnt_reg;
    logic [IW-1:0]   gidx_reg;
    logic [IW-1:0]   ptr_reg;
    logic [CW-1:0]   wdog_reg;
    logic            first_reg;
    logic            timeout_reg;
    logic            err_reg;
    logic [15:0]     pkts_reg;

    logic [N-1:0]    pick_next;
    logic [IW-1:0]   pickIdx_next;
    logic            found;
    logic [31:0]     masked [N];
    logic [31:0]     wrData;
    logic            fwd;
    logic [1:0]      flitType;
    logic            isTail;
    logic            idleTick;
    logic            expire;
    logic            protoErr;
    logic [IW-1:0]   ptr_next;

    // First requester at or after the priority pointer, searching upward mod N
    always_comb begin
        pick_next    = '0;
        pickIdx_next = '0;
        found        = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && Req_i[(int'(ptr_reg) + k) % N]) begin
                found                           = 1'b1;
                pick_next[(int'(ptr_reg) + k) % N] = 1'b1;
                pickIdx_next                    = IW'((int'(ptr_reg) + k) % N);
            end
        end
    end

    // Grant-masked flit slices; the one-hot grant turns the OR into a mux
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign masked[gi] = gnt_reg[gi] ? FifoWrData_i[32*gi +: 32] : 32'd0;
    end

    // OR-reduce the masked slices (zero when idle since no grant bit is set)
    always_comb begin
        wrData = '0;
        for (int k = 0; k < N; k++) begin
            wrData = wrData | masked[k];
        end
    end

    assign fwd      = (|(FifoWr_i & gnt_reg)) & ~FifoFull_i;
    assign flitType = wrData[31:30];
    assign isTail   = fwd && (flitType == 2'b11);
    assign idleTick = (state_reg == BUSY) && !fwd && !FifoFull_i;
    assign expire   = idleTick && (wdog_reg == CW'(TIMEOUT - 1));
    assign protoErr = fwd && ((first_reg && (flitType != 2'b00)) || (flitType == 2'b10));
    assign ptr_next = (gidx_reg == IW'(N - 1)) ? '0 : gidx_reg + IW'(1);

    // Arbiter FSM, watchdog, protocol checker and packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            gidx_reg    <= '0;
            ptr_reg     <= '0;
            wdog_reg    <= '0;
            first_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            err_reg     <= 1'b0;
            pkts_reg    <= '0;
        end else begin
            timeout_reg <= 1'b0;
            if (protoErr) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        state_reg <= BUSY;
                        gnt_reg   <= pick_next;
                        gidx_reg  <= pickIdx_next;
                        wdog_reg  <= '0;
                        first_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    if (fwd) begin
                        wdog_reg  <= '0;
                        first_reg <= 1'b0;
                        if (isTail) begin
                            state_reg <= IDLE;
                            gnt_reg   <= '0;
                            ptr_reg   <= ptr_next;
                            pkts_reg  <= pkts_reg + 16'd1;
                        end
                    end else if (expire) begin
                        // Source went silent too long: release and flag it
                        state_reg   <= IDLE;
                        gnt_reg     <= '0;
                        ptr_reg     <= ptr_next;
                        wdog_reg    <= '0;
                        timeout_reg <= 1'b1;
                        err_reg     <= 1'b1;
                    end else if (idleTick) begin
                        wdog_reg <= wdog_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Gnt_o        = gnt_reg;
    assign FullOut_o    = ~gnt_reg | {N{FifoFull_i}};
    assign FifoWr_o     = fwd;
    assign FifoWrData_o = wrData;
    assign Timeout_o    = timeout_reg;
    assign Err_o        = err_reg;
    assign PktCnt_o     = pkts_reg;

endmodule

// File: tb/tb_ni_fifo_arbiter.sv
// Randomized bench for ni_fifo_arbiter: behavioural sources drive flit
// packets and a packet-level reference model predicts every output each cycle.
module tb_ni_fifo_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    Req_i;
    logic [N-1:0]    FifoWr_i;
    logic [32*N-1:0] FifoWrData_i;
    logic            FifoFull_i;
    logic [N-1:0]    FullOut_o;
    logic [N-1:0]    Gnt_o;
    logic            FifoWr_o;
    logic [31:0]     FifoWrData_o;
    logic            Timeout_o;
    logic            Err_o;
    logic [15:0]     PktCnt_o;

    always #5 clk = ~clk;

    ni_fifo_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .Req_i        (Req_i),
        .FifoWr_i     (FifoWr_i),
        .FifoWrData_i (FifoWrData_i),
        .FullOut_o    (FullOut_o),
        .Gnt_o        (Gnt_o),
        .FifoFull_i   (FifoFull_i),
        .FifoWr_o     (FifoWr_o),
        .FifoWrData_o (FifoWrData_o),
        .Timeout_o    (Timeout_o),
        .Err_o        (Err_o),
        .PktCnt_o     (PktCnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, where priority starts, idle count
    bit mBusy, mFirst, mErr, mTo;
    int mOwner, mPtr, mWd, mPkts;

    // Behavioural sources
    bit pend [N];
    int fidx [N];
    int flen [N];
    int stall [N];

    int fullPct, corruptPct, stallPct, wrPct, spawnPct;
    bit garbage;
    int cyc = 0;
    int headCyc = -1000;
    int toCyc = -1;

    function automatic void model_reset();
        mBusy  = 1'b0;
        mFirst = 1'b0;
        mErr   = 1'b0;
        mTo    = 1'b0;
        mOwner = 0;
        mPtr   = 0;
        mWd    = 0;
        mPkts  = 0;
        for (int i = 0; i < N; i++) begin
            fidx[i]  = 0;
            stall[i] = 0;
        end
    endfunction

    task automatic clock_cycle(input bit doRst);
        logic [1:0]   t;
        logic [N-1:0] expFull;
        logic [N-1:0] expGnt;
        logic [31:0]  expData;
        bit           fwd;
        int           o;
        @(negedge clk);
        rst        = doRst;
        FifoFull_i = ($urandom_range(99) < fullPct);
        for (int i = 0; i < N; i++) begin
            Req_i[i] = pend[i];
            t = (fidx[i] == 0) ? 2'b00 : ((fidx[i] >= flen[i] - 1) ? 2'b11 : 2'b01);
            if ($urandom_range(99) < corruptPct)
                t = ($urandom_range(1) == 1) ? 2'b10 : 2'b01;
            FifoWrData_i[32*i +: 32] = {t, 30'($urandom)};
            if (mBusy && mOwner == i) begin
                if (stall[i] > 0) begin
                    FifoWr_i[i] = 1'b0;
                    stall[i]--;
                end else begin
                    FifoWr_i[i] = ($urandom_range(99) < wrPct);
                end
            end else begin
                FifoWr_i[i] = garbage && ($urandom_range(2) == 0);
            end
        end
        #1;
        o       = mOwner;
        fwd     = mBusy && FifoWr_i[o] && !FifoFull_i;
        expData = mBusy ? FifoWrData_i[32*o +: 32] : 32'd0;
        expFull = '1;
        expGnt  = '0;
        if (mBusy) begin
            expFull[o] = FifoFull_i;
            expGnt[o]  = 1'b1;
        end
        check_val("gnt",     32'(Gnt_o),     32'(expGnt));
        check_val("fullout", 32'(FullOut_o), 32'(expFull));
        check_val("wr",      32'(FifoWr_o),  32'(fwd));
        check_val("data",    FifoWrData_o,   expData);
        check_val("timeout", 32'(Timeout_o), 32'(mTo));
        check_val("err",     32'(Err_o),     32'(mErr));
        check_val("pktcnt",  32'(PktCnt_o),  32'(mPkts & 16'hffff));
        if (Timeout_o === 1'b1) toCyc = cyc;
        if (fwd && mFirst && expData[31:30] == 2'b00) headCyc = cyc;

        if (doRst) begin
            model_reset();
        end else begin
            mTo = 1'b0;
            if (mBusy) begin
                if (fwd) begin
                    t = expData[31:30];
                    if ((mFirst && t != 2'b00) || t == 2'b10) mErr = 1'b1;
                    mFirst = 1'b0;
                    mWd    = 0;
                    if (t == 2'b11) begin
                        mBusy = 1'b0;
                        mPtr  = (o + 1) % N;
                        mPkts++;
                        $display("pkt  src=%0d count=%0d cyc=%0d", o, mPkts, cyc);
                        fidx[o] = 0;
                        pend[o] = ($urandom_range(1) == 1);
                        flen[o] = $urandom_range(5, 2);
                    end else begin
                        if (fidx[o] == 0 && $urandom_range(99) < stallPct)
                            stall[o] = TIMEOUT + $urandom_range(8);
                        fidx[o]++;
                    end
                end else if (!FifoFull_i) begin
                    mWd++;
                    if (mWd == TIMEOUT) begin
                        mBusy    = 1'b0;
                        mPtr     = (o + 1) % N;
                        mTo      = 1'b1;
                        mErr     = 1'b1;
                        mWd      = 0;
                        fidx[o]  = 0;
                        stall[o] = 0;
                        $display("tout src=%0d cyc=%0d", o, cyc);
                    end
                end
            end else if (Req_i != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (!mBusy && Req_i[(mPtr + k) % N]) begin
                        mBusy  = 1'b1;
                        mOwner = (mPtr + k) % N;
                    end
                end
                mFirst = 1'b1;
                mWd    = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(99) < spawnPct) begin
                    pend[i] = 1'b1;
                    flen[i] = $urandom_range(5, 2);
                end
            end
        end
        cyc++;
    endtask

    initial begin
        rst          = 1'b1;
        Req_i        = '0;
        FifoWr_i     = '0;
        FifoWrData_i = '0;
        FifoFull_i   = 1'b0;
        fullPct      = 0;
        corruptPct   = 0;
        stallPct     = 0;
        wrPct        = 100;
        spawnPct     = 0;
        garbage      = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            flen[i] = 3;
        end
        repeat (3) @(posedge clk);
        model_reset();

        // Reset state
        clock_cycle(1'b1);
        clock_cycle(1'b1);

        // Source 1 writes its head then goes silent; source 3 waits its turn
        stallPct = 100;
        pend[1]  = 1'b1;
        pend[3]  = 1'b1;
        for (int c = 0; c < 200 && toCyc < 0; c++) clock_cycle(1'b0);
        // Head is captured at the end of its cycle; the pulse appears
        // TIMEOUT edges later, i.e. in the sampled cycle TIMEOUT+1 after it
        check_val("to_latency", 32'(toCyc - headCyc), 32'(TIMEOUT + 1));
        repeat (20) clock_cycle(1'b0);

        // Randomized traffic with occasional resets, stalls and bad flits
        stallPct   = 5;
        corruptPct = 2;
        wrPct      = 70;
        spawnPct   = 10;
        garbage    = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 1000 == 0) fullPct = $urandom_range(40);
            clock_cycle($urandom_range(999) < 3);
        end

        // Long FIFO-full hold must never trip the watchdog
        fullPct = 100;
        repeat (120) clock_cycle(1'b0);
        fullPct = 10;
        repeat (300) clock_cycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
